// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encodings, default width and counter sizing
package serial_sub_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    localparam int DEFAULT_WIDTH = 8;
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit x - y - borrow_in step
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);
    assign diff       = x ^ y ^ borrow_in;
    assign borrow_out = (~x & y) | (~(x ^ y) & borrow_in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock; SERIAL_SUB_OVERFLOW_EN adds the signed overflow flag
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);
    localparam int CW = cnt_width(WIDTH);
    state_t state, state_n;
    logic [WIDTH-1:0] a_r, b_r;
    logic [CW-1:0] cnt;
    logic last, accept, d, bo;

    full_subtractor u_fs (
        .x(a_r[0]),
        .y(b_r[0]),
        .borrow_in(borrow_out),
        .diff(d),
        .borrow_out(bo)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    // next-state and status decode
    always_comb begin
        state_n      = state;
        last         = cnt == CW'(WIDTH - 1);
        accept       = state == IDLE && start;
        busy         = state != IDLE;
        result_valid = state == DONE;
        case (state)
            IDLE:    state_n = start ? SHIFT : IDLE;
            SHIFT:   state_n = last ? DONE : SHIFT;
            DONE:    state_n = result_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // operand shifters, borrow flop, result register and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            cnt        <= '0;
        end else if (accept) begin
            a_r        <= a;
            b_r        <= b;
            borrow_out <= 1'b0;
            cnt        <= '0;
        end else if (state == SHIFT) begin
            diff       <= {d, diff[WIDTH-1:1]};
            a_r        <= a_r >> 1;
            b_r        <= b_r >> 1;
            borrow_out <= bo;
            cnt        <= last ? '0 : cnt + 1'b1;
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    // on the last step a_r[0]/b_r[0] are the original sign bits and d is the result sign
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else if (accept) overflow <= 1'b0;
        else if (state == SHIFT && last) overflow <= (a_r[0] != b_r[0]) && (d != a_r[0]);
    end
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor; SERIAL_SUB_OVERFLOW_EN also checks overflow
module tb_serial_subtractor;
    localparam int W = 8;
    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         result_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] diff;
    logic         busy, result_valid, borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         overflow;
`endif

    exp_t sb[$];
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .diff(diff),
        .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow(overflow)
`endif
    );

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.d  = x - y;
        e.br = x < y;
`ifdef SERIAL_SUB_OVERFLOW_EN
        e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
`else
        e.ov = 1'b0;
`endif
        return e;
    endfunction

    function automatic exp_t cur();
        exp_t o;
        o.d  = diff;
        o.br = borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
        o.ov = overflow;
`else
        o.ov = 1'b0;
`endif
        return o;
    endfunction

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        if (push) sb.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({busy, result_valid, cur()} !== '0)
            $display("FAIL reset_state got busy=%b rv=%b out=%h want all zero", busy, result_valid, cur());
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[9];
        logic [W-1:0] vb[9];
        int n;
        exp_t e;
        va = '{8'h05, 8'h03, 8'h80, 8'h5A, 8'h00, 8'hFF, 8'h7F, 8'h01, 8'hC3};
        vb = '{8'h03, 8'h05, 8'h01, 8'h5A, 8'hFF, 8'h00, 8'hFF, 8'h80, 8'h3C};
        result_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            issue(va[i], vb[i], 1'b1);
            wait_valid(n);
            total++;
            if (n !== W) $display("FAIL vec%0d_latency got %0d want %0d", i, n, W);
            else passed++;
            e = sb.pop_front();
            total++;
            if (cur() !== e) $display("FAIL vec%0d_result a=%h b=%h got %h want %h", i, va[i], vb[i], cur(), e);
            else passed++;
            @(negedge clk);
            total++;
            if ({busy, result_valid} !== 2'b00) $display("FAIL vec%0d_idle got busy=%b rv=%b want 0 0", i, busy, result_valid);
            else passed++;
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        int seen;
        exp_t e;
        result_ready = 1'b1;
        issue(8'h10, 8'h01, 1'b1);
        repeat (3) @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(n);
        e = sb.pop_front();
        total++;
        if (!result_valid || cur() !== e) $display("FAIL busy_start_result got rv=%b %h want 1 %h", result_valid, cur(), e);
        else passed++;
        seen = 0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        total++;
        if (seen !== 0 || busy !== 1'b0) $display("FAIL busy_start_extra got %0d valids busy=%b want 0 0", seen, busy);
        else passed++;
    endtask

    task automatic test_backpressure();
        int n;
        exp_t e;
        result_ready = 1'b0;
        issue(8'hA5, 8'h3C, 1'b1);
        wait_valid(n);
        e = sb.pop_front();
        total++;
        if (cur() !== e) $display("FAIL bp_result got %h want %h", cur(), e);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (!result_valid || !busy || cur() !== e)
                $display("FAIL bp_hold%0d got rv=%b busy=%b %h want 1 1 %h", i, result_valid, busy, cur(), e);
            else passed++;
        end
        result_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, result_valid} !== 2'b00 || cur() !== e)
            $display("FAIL bp_release got busy=%b rv=%b %h want 0 0 %h", busy, result_valid, cur(), e);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        exp_t e;
        result_ready = 1'b1;
        issue(8'h5A, 8'h21, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, result_valid, cur()} !== '0)
            $display("FAIL rst_mid_outputs got busy=%b rv=%b out=%h want all zero", busy, result_valid, cur());
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (result_valid || busy) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL rst_mid_ghost got %0d active cycles want 0", seen);
        else passed++;
        issue(8'h5A, 8'h21, 1'b1);
        wait_valid(n);
        e = sb.pop_front();
        total++;
        if (n !== W || cur() !== e) $display("FAIL rst_mid_next got lat=%0d %h want %0d %h", n, cur(), W, e);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n;
        exp_t e;
        logic [W-1:0] x, y;
        result_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            issue(x, y, 1'b1);
            wait_valid(n);
            e = sb.pop_front();
            total++;
            if (n !== W || cur() !== e) $display("FAIL b2b%0d a=%h b=%h got lat=%0d %h want %0d %h", i, x, y, n, cur(), W, e);
            else passed++;
        end
        total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_left got %0d want 0", sb.size());
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_vectors();
        test_start_while_busy();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to subtract; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend; sampled on the accepting edge.
REQ-006 b  input  WIDTH  subtrahend; sampled on the accepting edge.
REQ-007 busy  output  1  high in SHIFT and DONE.
REQ-008 result_valid  output  1  high in DONE only.
REQ-009 result_ready  input  1  consumer accepts the result.
REQ-010 diff  output  WIDTH  a minus b, modulo 2^WIDTH.
REQ-011 borrow_out  output  1  high when a < b (unsigned).
REQ-012 overflow  output  1  two's-complement overflow flag; port exists only with SERIAL_SUB_OVERFLOW_EN.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 Operation in IDLE:
- start=1 latches a and b, clears the borrow flop and bit counter, and moves to SHIFT.
- start=0 stays in IDLE.
REQ-015 Each SHIFT cycle SHALL:
- run one full-subtractor step on the operand LSBs and the borrow flop;
- shift the difference bit into the result MSB;
- right-shift both operands;
- increment the counter.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, then enter DONE; result_valid is high WIDTH cycles after the accepting edge.
REQ-017 In DONE: diff, borrow_out and overflow are held stable until result_valid and result_ready are both high on an edge; the FSM then returns to IDLE.
REQ-018 start is ignored in SHIFT and DONE; a new start is accepted no earlier than the cycle after returning to IDLE.
REQ-019 result_ready outside DONE has no effect.
REQ-020 diff, borrow_out and overflow are registered outputs; no combinational path from inputs to outputs.
REQ-021 Boundary cases:
- a == b gives diff=0, borrow_out=0.
- 0 minus all-ones gives diff=1, borrow_out=1.

Reset
REQ-022 rst_n low SHALL immediately force IDLE and set busy=0, result_valid=0, diff=0, borrow_out=0, overflow=0, counter=0.
REQ-023 Reset asserted mid-SHIFT or mid-DONE SHALL discard the operation; no result_valid follows release.
REQ-024 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-025 Macro SERIAL_SUB_OVERFLOW_EN, when defined:
- adds the overflow port and its logic;
- overflow = (a_msb != b_msb) && (diff_msb != a_msb), registered with diff.
REQ-026 Without the macro, the overflow port and logic are absent; all other behaviour and latency are unchanged.

Structure
REQ-027 Shared package/include serial_sub_pkg SHALL hold:
- the FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
- the default WIDTH constant;
- the counter-width function (clog2).
REQ-028 One combinational sub-module, full_subtractor (ports x, y, borrow_in, diff, borrow_out), SHALL be instantiated once for the per-bit step.

Verification
REQ-029 Basic subtract: a=0x05, b=0x03, start pulse -> result_valid after 8 cycles, diff=0x02, borrow_out=0, overflow=0.
REQ-030 Borrow case: a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0.
REQ-031 Signed overflow: a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1 (macro defined); overflow port absent when undefined.
REQ-032 Start while busy: start with a=0x10, b=0x01, then start again mid-SHIFT with a=0xFF, b=0xFF -> result diff=0x0F, only one result_valid.
REQ-033 Backpressure: result_ready low for 5 cycles after result_valid -> diff/flags constant; ready high -> IDLE next cycle, busy=0.
REQ-034 Reset mid-operation: rst_n low at SHIFT cycle 4 -> all outputs 0 at once, no result_valid after release, next start computes correctly.
